// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I width
// codes and the store lane mask / data replication used on the memory port.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants share the low two bits with their signed forms, so the
  // lane selection only needs funct3[1:0].
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = i_rdata >> {i_off, 3'b000};
    o_data  = 32'd0;
    case (i_funct3)
      F3_B:    o_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    o_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    o_data = shifted;
      F3_BU:   o_data = {24'd0, shifted[7:0]};
      F3_HU:   o_data = {16'd0, shifted[15:0]};
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store stage: issues one req/ack data-memory access per instruction and
// stalls the core until it completes. Optional ack timeout via LSU_TIMEOUT_EN.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned,
  output logic            o_illegal,
  output logic            o_timeout,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_mask,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [3:0]      mask_q, mask_d;
  logic            we_q, we_d;
  logic            misaligned_q, misaligned_d;
  logic            illegal_q, illegal_d;
  logic            width_ok, illegal_in, misaligned_in;
  logic [XLEN-1:0] load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // A valid op that is neither or both of load/store has nothing sane to do,
  // so it is reported as illegal rather than touching memory.
  always_comb begin
    width_ok = 1'b0;
    case (i_funct3)
      F3_B, F3_H, F3_W: width_ok = 1'b1;
      F3_BU, F3_HU:     width_ok = i_is_load;
      default:          width_ok = 1'b0;
    endcase
    illegal_in    = !width_ok || (i_is_load == i_is_store);
    misaligned_in = width_ok &&
                    ((i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                     (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00));
  end

  lsu_load_align u_align (
    .i_rdata  (rdata_q),
    .i_off    (addr_q[1:0]),
    .i_funct3 (funct3_q),
    .o_data   (load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      funct3_q     <= 3'd0;
      mask_q       <= 4'd0;
      we_q         <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      funct3_q     <= funct3_d;
      mask_q       <= mask_d;
      we_q         <= we_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    funct3_d     = funct3_q;
    mask_d       = mask_q;
    we_d         = we_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          addr_d       = i_addr;
          funct3_d     = i_funct3;
          we_d         = i_is_store && !i_is_load;
          wdata_d      = (i_is_store && !i_is_load) ? store_data(i_funct3, i_wdata) : '0;
          mask_d       = lane_mask(i_funct3, i_addr[1:0]);
          rdata_d      = '0;
          misaligned_d = misaligned_in;
          illegal_d    = illegal_in;
`ifdef LSU_TIMEOUT_EN
          cnt_d        = '0;
          timeout_d    = 1'b0;
`endif
          state_d      = (misaligned_in || illegal_in) ? DONE : REQ;
        end
      end
      REQ: begin
        if (i_dmem_ack) begin
          rdata_d = i_dmem_rdata;
          state_d = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_rdata      = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    o_timeout    = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_dmem_mask  = 4'd0;
    case (state_q)
      IDLE: o_busy = i_valid;
      REQ: begin
        o_busy       = 1'b1;
        o_dmem_req   = 1'b1;
        o_dmem_we    = we_q;
        o_dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        o_dmem_wdata = wdata_q;
        o_dmem_mask  = mask_q;
      end
      DONE: begin
        o_done       = 1'b1;
        o_misaligned = misaligned_q;
        o_illegal    = illegal_q;
`ifdef LSU_TIMEOUT_EN
        o_timeout    = timeout_q;
        o_rdata      = (we_q || misaligned_q || illegal_q || timeout_q) ? '0 : load_data;
`else
        o_rdata      = (we_q || misaligned_q || illegal_q) ? '0 : load_data;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: loads, stores, flagged accesses, async
// reset mid-request and (with LSU_TIMEOUT_EN) the ack timeout.
module tb_lsu_mem_access;

  logic        clk;
  logic        rst_n;
  logic        valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, misaligned, illegal, timeout;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_access dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_is_load    (is_load),
    .i_is_store   (is_store),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_rdata      (rdata),
    .o_misaligned (misaligned),
    .o_illegal    (illegal),
    .o_timeout    (timeout),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .o_dmem_mask  (dmem_mask),
    .i_dmem_ack   (dmem_ack),
    .i_dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid    = 1'b1;
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
  endtask

  task automatic release_op();
    valid    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int req_cnt;
    rst_n = 1'b0;
    release_op();
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mask", {28'd0, dmem_mask}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LB 0x103, ack in first REQ cycle
    @(negedge clk); issue(1, 0, 3'b000, 32'h103, 32'd0); #1;
    chk("lb_busy_c0", {31'd0, busy}, 32'd1);
    chk("lb_req_c0", {31'd0, dmem_req}, 32'd0);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234; #1;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_mask", {28'd0, dmem_mask}, 32'h8);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_busy_done", {31'd0, busy}, 32'd0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_flags", {29'd0, misaligned, illegal, timeout}, 32'd0);
    @(negedge clk); release_op(); #1;
    chk("lb_done_gone", {31'd0, done}, 32'd0);

    // LHU 0x102, three wait cycles then ack
    @(negedge clk); issue(1, 0, 3'b101, 32'h102, 32'd0); #1;
    busy_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      dmem_ack = (k == 4);
      dmem_rdata = 32'h8001_0000;
      #1;
      if (busy) busy_cnt++;
      chk($sformatf("lhu_req_c%0d", k), {31'd0, dmem_req}, 32'd1);
    end
    chk("lhu_mask", {28'd0, dmem_mask}, 32'hC);
    chk("lhu_busy_cycles", busy_cnt, 32'd4);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("lhu_done", {31'd0, done}, 32'd1);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    @(negedge clk); release_op(); dmem_ack = 1'b1; #1;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("idle_ack_ignored", {30'd0, done, dmem_req}, 32'd0);

    // SB 0x201
    @(negedge clk); issue(0, 1, 3'b000, 32'h201, 32'h1234_56AB); #1;
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_addr", dmem_addr, 32'h200);
    chk("sb_mask", {28'd0, dmem_mask}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_rdata", rdata, 32'd0);
    @(negedge clk); release_op();

    // SH 0x302
    @(negedge clk); issue(0, 1, 3'b001, 32'h302, 32'h1111_BEEF); #1;
    @(negedge clk); dmem_ack = 1'b1; #1;
    chk("sh_mask", {28'd0, dmem_mask}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("sh_done", {31'd0, done}, 32'd1);
    @(negedge clk); release_op();

    // LH 0x100 sign-extended
    @(negedge clk); issue(1, 0, 3'b001, 32'h100, 32'd0); #1;
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h1234_F00D; #1;
    chk("lh_mask", {28'd0, dmem_mask}, 32'h3);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("lh_rdata", rdata, 32'hFFFF_F00D);
    @(negedge clk); release_op();

    // LW misaligned: no memory access, done after one cycle
    @(negedge clk); issue(1, 0, 3'b010, 32'h102, 32'd0); #1;
    chk("lw_mis_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    chk("lw_mis_done", {31'd0, done}, 32'd1);
    chk("lw_mis_flag", {30'd0, misaligned, illegal}, 32'h2);
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_rdata", rdata, 32'd0);
    @(negedge clk); release_op();

    // funct3 011 load -> illegal
    @(negedge clk); issue(1, 0, 3'b011, 32'h100, 32'd0); #1;
    @(negedge clk); #1;
    chk("f3_011_flag", {29'd0, done, misaligned, illegal}, 32'h5);
    chk("f3_011_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk); release_op();

    // SBU (funct3 100 store) -> illegal
    @(negedge clk); issue(0, 1, 3'b100, 32'h100, 32'd0); #1;
    @(negedge clk); #1;
    chk("sbu_illegal", {29'd0, done, misaligned, illegal}, 32'h5);
    @(negedge clk); release_op();

    // load and store both set -> illegal
    @(negedge clk); issue(1, 1, 3'b000, 32'h100, 32'd0); #1;
    @(negedge clk); #1;
    chk("ldst_illegal", {29'd0, done, misaligned, illegal}, 32'h5);
    @(negedge clk); release_op();

    // async reset during REQ
    @(negedge clk); issue(1, 0, 3'b010, 32'h400, 32'd0); #1;
    @(negedge clk); #1;
    chk("rst_mid_req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_mid_req_drop", {31'd0, dmem_req}, 32'd0);
    @(negedge clk); release_op(); #1;
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); issue(1, 0, 3'b000, 32'h401, 32'd0); #1;
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h0000_5A00; #1;
    chk("post_rst_addr", dmem_addr, 32'h400);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_rdata", rdata, 32'h0000_005A);
    @(negedge clk); release_op();

`ifdef LSU_TIMEOUT_EN
    // never ack: timeout after 255 REQ cycles
    @(negedge clk); issue(1, 0, 3'b010, 32'h500, 32'd0); #1;
    req_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (done) break;
      if (dmem_req) req_cnt++;
    end
    chk("to_req_cycles", req_cnt, 32'd255);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    @(negedge clk); release_op();
`else
    req_cnt = 0;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
